lift_motion_controller: RTL

Sequencing controller for the lift car: latches floor-call requests, chooses travel direction with a sweep policy (keep going while calls remain ahead, otherwise reverse), drives `direction`/`motion` into the lift movement emulator, watches its `floor_sense` contacts to detect arrival, and holds the door open for a fixed dwell. It sits between the call-button inputs and the car drive, and is the only block that may command motion.

---
 rtl/lift_motion_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lift_motion_controller.sv
// Lift car sequencing controller: latches floor calls, runs a sweep travel policy,
// commands the car drive, detects arrival from floor contacts and times the door dwell.
module lift_motion_controller #(
    parameter int N_FLOORS      = 12,
    parameter int DOOR_OPEN_CYC = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] floor_req,
    input  logic [N_FLOORS-1:0] floor_sense,
    output logic                direction,
    output logic                motion,
    output logic                door_open,
    output logic [N_FLOORS-1:0] cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                fault
);

    localparam int                  TW        = $clog2(DOOR_OPEN_CYC);
    localparam logic [TW-1:0]       DOOR_LOAD = TW'(DOOR_OPEN_CYC - 1);
    localparam logic [TW-1:0]       TIMER_ONE = TW'(1);
    localparam logic [N_FLOORS-1:0] FLOOR_ONE = N_FLOORS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR,
        ST_FAULT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_dir, w_dir_nxt;
    logic                r_motion, w_motion_nxt;
    logic                r_door, w_door_nxt;
    logic                r_fault, w_fault_nxt;
    logic [N_FLOORS-1:0] r_cur, w_cur_nxt;
    logic [N_FLOORS-1:0] r_pend, w_pend_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [N_FLOORS-1:0] w_clr;

    logic                w_sense_multi;
    logic                w_sense_onehot;
    logic [N_FLOORS-1:0] w_cur_eff;
    logic [N_FLOORS-1:0] w_below_mask;
    logic [N_FLOORS-1:0] w_above_mask;
    logic                w_ahead_up;
    logic                w_ahead_dn;
    logic                w_call_here;
    logic                w_new_floor;
    logic                w_end_of_shaft;

    // A contact pattern with two or more bits set is a wiring/contact fault.
    assign w_sense_multi  = |(floor_sense & (floor_sense - FLOOR_ONE));
    assign w_sense_onehot = (|floor_sense) && !w_sense_multi;

    // While idle the contacts resync the car position, so decide from the sensed floor.
    assign w_cur_eff      = (r_state == ST_IDLE && w_sense_onehot) ? floor_sense : r_cur;
    assign w_below_mask   = w_cur_eff - FLOOR_ONE;
    assign w_above_mask   = ~(w_cur_eff | w_below_mask);
    assign w_ahead_up     = |(r_pend & w_above_mask);
    assign w_ahead_dn     = |(r_pend & w_below_mask);
    assign w_call_here    = |(r_pend & w_cur_eff);

    assign w_new_floor    = w_sense_onehot && (floor_sense != r_cur);
    assign w_end_of_shaft = (r_dir && floor_sense[N_FLOORS-1]) || (!r_dir && floor_sense[0]);

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_motion_nxt = r_motion;
        w_door_nxt   = r_door;
        w_fault_nxt  = r_fault;
        w_cur_nxt    = r_cur;
        w_timer_nxt  = r_timer;
        w_clr        = '0;

        if (w_sense_multi) begin
            w_state_nxt  = ST_FAULT;
            w_motion_nxt = 1'b0;
            w_door_nxt   = 1'b0;
            w_fault_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_motion_nxt = 1'b0;
                    w_door_nxt   = 1'b0;
                    w_cur_nxt    = w_cur_eff;
                    if (w_call_here) begin
                        w_state_nxt = ST_DOOR;
                        w_clr       = w_cur_eff;
                        w_door_nxt  = 1'b1;
                        w_timer_nxt = DOOR_LOAD;
                    end else if (r_dir ? w_ahead_up : w_ahead_dn) begin
                        w_state_nxt  = ST_MOVE;
                        w_motion_nxt = 1'b1;
                    end else if (r_dir ? w_ahead_dn : w_ahead_up) begin
                        w_state_nxt  = ST_MOVE;
                        w_dir_nxt    = ~r_dir;
                        w_motion_nxt = 1'b1;
                    end
                end

                ST_MOVE: begin
                    w_motion_nxt = 1'b1;
                    if (w_new_floor) begin
                        w_cur_nxt = floor_sense;
                        if (|(r_pend & floor_sense)) begin
                            w_state_nxt  = ST_DOOR;
                            w_clr        = floor_sense;
                            w_motion_nxt = 1'b0;
                            w_door_nxt   = 1'b1;
                            w_timer_nxt  = DOOR_LOAD;
                        end else if (w_end_of_shaft) begin
                            w_state_nxt  = ST_IDLE;
                            w_motion_nxt = 1'b0;
                        end
                    end
                end

                ST_DOOR: begin
                    w_motion_nxt = 1'b0;
                    w_door_nxt   = 1'b1;
                    // A fresh call for this floor keeps the door open for another full dwell.
                    if (|(floor_req & r_cur)) begin
                        w_clr       = r_cur;
                        w_timer_nxt = DOOR_LOAD;
                    end else if (r_timer == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_door_nxt  = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_ONE;
                    end
                end

                ST_FAULT: begin
                    w_motion_nxt = 1'b0;
                    w_door_nxt   = 1'b0;
                    w_fault_nxt  = 1'b1;
                end
            endcase
        end
    end

    // Clearing the served floor wins over a same-cycle request for it.
    assign w_pend_nxt = (r_pend | floor_req) & ~w_clr;

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dir    <= 1'b1;
            r_motion <= 1'b0;
            r_door   <= 1'b0;
            r_fault  <= 1'b0;
            r_cur    <= FLOOR_ONE;
            r_pend   <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_motion <= w_motion_nxt;
            r_door   <= w_door_nxt;
            r_fault  <= w_fault_nxt;
            r_cur    <= w_cur_nxt;
            r_pend   <= w_pend_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign direction = r_dir;
    assign motion    = r_motion;
    assign door_open = r_door;
    assign cur_floor = r_cur;
    assign pending   = r_pend;
    assign fault     = r_fault;

endmodule
